// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - operand/result bundle between the E stage and the divider
//
// Purpose: groups the divider's handshake and datapath signals.
//   start    E-stage instruction is a divide/remainder (held while in E)
//   flush    E-stage flush, aborts any operation
//   op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word     W variant (low 32 bits, result sign-extended from bit 31)
//   a, b     dividend / divisor after forwarding
//   result   registered result, valid while done=1
//   done     one-cycle result-valid pulse
//   busy     divider is iterating
//   stallReq stall F/D and hold E
// Modports: master drives the request (pipeline side), slave is the divider.
interface div_unit_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            flush;
    logic [1:0]      op;
    logic            word;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;
    logic            stallReq;

    modport master (
        output start, flush, op, word, a, b,
        input  result, done, busy, stallReq
    );

    modport slave (
        input  start, flush, op, word, a, b,
        output result, done, busy, stallReq
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring RV64M divider (DIV/DIVU/REM/REMU and W forms)
//
// Purpose: one quotient bit per cycle, MSB first, on operand magnitudes; signs are
// restored when the result is written. Divide-by-zero and signed overflow bypass
// the iteration and complete in one cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   dif    div_unit_if slave modport (start/flush/op/word/a/b in,
//          result/done/busy/stallReq out)
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  dif
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;     // holds remaining dividend bits, fills with quotient bits
    logic [XLEN-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            negq_q, negq_d;   // negate quotient on completion
    logic            negr_q, negr_d;   // negate remainder on completion
    logic [XLEN-1:0] result_q, result_d;

    // Operand preparation (only meaningful in the IDLE accept cycle)
    logic            is_signed;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val;
    logic            a_neg, b_neg, div_zero, ovf, special, accept;
    logic [XLEN-1:0] spec_res;

    // Iteration step
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] sub, rem_nx, quo_nx, fin_q, fin_r, calc_res;
    logic            ge;

    // Select quotient/remainder and apply the W-form sign extension of bit 31.
    function automatic logic [XLEN-1:0] pick(input logic sel_rem, input logic w,
                                             input logic [XLEN-1:0] q,
                                             input logic [XLEN-1:0] r);
        logic [XLEN-1:0] v;
        v = sel_rem ? r : q;
        if (w) v = {{(XLEN-32){v[31]}}, v[31:0]};
        return v;
    endfunction

    always_comb begin
        is_signed = ~dif.op[0];
        if (dif.word) begin
            a_ext = {{(XLEN-32){is_signed & dif.a[31]}}, dif.a[31:0]};
            b_ext = {{(XLEN-32){is_signed & dif.b[31]}}, dif.b[31:0]};
            min_val = {{(XLEN-31){1'b1}}, 31'd0};
        end else begin
            a_ext = dif.a;
            b_ext = dif.b;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg = is_signed & a_ext[XLEN-1];
        b_neg = is_signed & b_ext[XLEN-1];
        a_abs = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_abs = b_neg ? (~b_ext + 1'b1) : b_ext;
        div_zero = (b_ext == '0);
        ovf = is_signed & (a_ext == min_val) & (b_ext == '1);
        special = div_zero | ovf;
        // Special results use the extended operands directly, no sign fix-up.
        spec_res = pick(dif.op[1], dif.word,
                        div_zero ? '1 : a_ext,
                        div_zero ? a_ext : '0);
        accept = (state_q == S_IDLE) & dif.start & ~dif.flush;
    end

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        ge = (rem_sh >= {1'b0, dvs_q});
        // When ge, the difference is below the divisor so it fits in XLEN bits.
        sub = rem_sh[XLEN-1:0] - dvs_q;
        rem_nx = ge ? sub : rem_sh[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ge};
        fin_q = negq_q ? (~quo_nx + 1'b1) : quo_nx;
        fin_r = negr_q ? (~rem_nx + 1'b1) : rem_nx;
        calc_res = pick(op_q[1], word_q, fin_q, fin_r);
    end

    // Datapath next state
    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        op_d = op_q;
        word_d = word_q;
        negq_d = negq_q;
        negr_d = negr_q;
        result_d = result_q;
        if (accept) begin
            op_d = dif.op;
            word_d = dif.word;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            rem_d = '0;
            dvs_d = b_abs;
            // W forms start with the 32-bit dividend left-aligned so 32 steps consume it.
            quo_d = dif.word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
            if (special) begin
                cnt_d = '0;
                result_d = spec_res;
            end else begin
                cnt_d = dif.word ? CW'(32) : CW'(XLEN);
            end
        end else if (state_q == S_CALC && !dif.flush) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) result_d = calc_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            op_q <= '0;
            word_q <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            op_q <= op_d;
            word_q <= word_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            result_q <= result_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (dif.start && !dif.flush) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (dif.flush)              state_d = S_IDLE;
                else if (cnt_q == CW'(1))   state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;     // start is still high for the same instruction
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        dif.busy = (state_q == S_CALC);
        dif.done = (state_q == S_DONE);
        dif.stallReq = ((state_q == S_IDLE) & dif.start & ~dif.flush) | (state_q == S_CALC);
        dif.result = result_q;
    end
endmodule
